// File: rtl/bit_enumerator_if.sv
// Stream interface for bit_enumerator: mask in, one set-bit index per beat out,
// plus the completion pulse and population count.
interface bit_enumerator_if #(
  parameter int WIDTH = 32,
  parameter int IDX_W = $clog2(WIDTH)
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_mask;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_index;
  logic [IDX_W:0]   out_ord;
  logic             out_last;
  logic             done;
  logic [IDX_W:0]   total;

  modport master (
    output in_valid, in_mask, out_ready,
    input  in_ready, out_valid, out_index, out_ord, out_last, done, total
  );

  modport slave (
    input  in_valid, in_mask, out_ready,
    output in_ready, out_valid, out_index, out_ord, out_last, done, total
  );
endinterface

// File: rtl/bit_enumerator.sv
// Walks a register mask lowest-bit-first, emitting one set-bit index per beat,
// then pulses done with the number of beats transferred.
module bit_enumerator #(
  parameter int WIDTH = 32,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  bit_enumerator_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

  localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);
  localparam logic [IDX_W:0]   ONE_ORD = (IDX_W+1)'(1);

  state_t           state, state_n;
  logic [WIDTH-1:0] remaining, remaining_n;
  logic [IDX_W:0]   ord, ord_n;
  logic             last;

  function automatic logic [IDX_W-1:0] lowest_idx(input logic [WIDTH-1:0] m);
    lowest_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (m[i]) lowest_idx = i[IDX_W-1:0];
    end
  endfunction

  function automatic logic single_bit(input logic [WIDTH-1:0] m);
    return (m != '0) && ((m & (m - ONE_W)) == '0);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
      ord       <= '0;
    end else begin
      state     <= state_n;
      remaining <= remaining_n;
      ord       <= ord_n;
    end
  end

  // Outputs decode from registered state only, so out_ready never reaches out_valid/out_index.
  always_comb begin
    state_n       = state;
    remaining_n   = remaining;
    ord_n         = ord;
    last          = single_bit(remaining);
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_index = '0;
    bus.out_ord   = '0;
    bus.out_last  = 1'b0;
    bus.done      = 1'b0;
    bus.total     = '0;
    unique case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          remaining_n = bus.in_mask;
          ord_n       = '0;
          state_n     = (bus.in_mask != '0) ? EMIT : DONE;
        end
      end
      EMIT: begin
        bus.out_valid = 1'b1;
        bus.out_index = lowest_idx(remaining);
        bus.out_ord   = ord;
        bus.out_last  = last;
        if (bus.out_ready) begin
          remaining_n = remaining & (remaining - ONE_W);
          ord_n       = ord + ONE_ORD;
          if (last) state_n = DONE;
        end
      end
      DONE: begin
        bus.done  = 1'b1;
        bus.total = ord;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
